// File: rtl/load_store_unit.sv
// Load/store unit: sizes, aligns and extends a single memory access, then runs one bus handshake with a timeout.
// Latency: an ack k cycles after the request gives done at k+1. Pipeline is held via stall while an access is open.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_out,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic          r_tmo;
    logic          r_we;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [31:0]   r_addr;
    logic [31:0]   r_rdata;

    logic          w_f3_ok, w_aligned, w_legal, w_start, w_illegal, w_tmo_hit;
    logic [3:0]    w_be;
    logic [31:0]   w_wd, w_load;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    always_comb begin
        w_f3_ok   = 1'b0;
        w_aligned = 1'b0;
        case (funct3)
            3'b000: begin w_f3_ok = 1'b1;       w_aligned = 1'b1;             end
            3'b001: begin w_f3_ok = 1'b1;       w_aligned = ~addr[0];         end
            3'b010: begin w_f3_ok = 1'b1;       w_aligned = (addr[1:0] == 2'b00); end
            3'b100: begin w_f3_ok = ~mem_write; w_aligned = 1'b1;             end
            3'b101: begin w_f3_ok = ~mem_write; w_aligned = ~addr[0];         end
            default: begin w_f3_ok = 1'b0;      w_aligned = 1'b0;             end
        endcase
    end

    assign w_legal   = (mem_read ^ mem_write) & w_f3_ok & w_aligned;
    assign w_start   = rst_n & (r_state == IDLE) & w_legal;
    assign w_illegal = rst_n & (r_state == IDLE) & (mem_read | mem_write) & ~w_legal;
    assign w_tmo_hit = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_be = 4'b1111;
        w_wd = wdata;
        case (funct3[1:0])
            2'b00: begin w_be = 4'b0001 << addr[1:0];        w_wd = {4{wdata[7:0]}};  end
            2'b01: begin w_be = 4'b0011 << {addr[1], 1'b0};  w_wd = {2{wdata[15:0]}}; end
            default: begin w_be = 4'b1111;                   w_wd = wdata;            end
        endcase
    end

    // Lane select follows addr, which the pipeline holds stable for the whole access.
    always_comb begin
        w_byte = bus_rdata[7:0];
        case (addr[1:0])
            2'b00: w_byte = bus_rdata[7:0];
            2'b01: w_byte = bus_rdata[15:8];
            2'b10: w_byte = bus_rdata[23:16];
            default: w_byte = bus_rdata[31:24];
        endcase
        w_half = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (funct3)
            3'b000: w_load = {{24{w_byte[7]}}, w_byte};
            3'b100: w_load = {24'd0, w_byte};
            3'b001: w_load = {{16{w_half[15]}}, w_half};
            3'b101: w_load = {16'd0, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_start) w_next = REQ;
            REQ:  if (bus_ack || w_tmo_hit) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_addr  <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_start) begin
                    r_we    <= mem_write;
                    r_be    <= w_be;
                    r_wdata <= mem_write ? w_wd : 32'd0;
                    r_addr  <= {addr[31:2], 2'b00};
                    r_cnt   <= '0;
                    r_tmo   <= 1'b0;
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!r_we) r_rdata <= w_load;
                    end else if (w_tmo_hit) begin
                        r_tmo <= 1'b1;
                        if (!r_we) r_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    r_we    <= 1'b0;
                    r_be    <= 4'd0;
                    r_wdata <= 32'd0;
                    r_addr  <= 32'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus_req   = (r_state == REQ);
    assign bus_we    = r_we;
    assign bus_be    = r_be;
    assign bus_wdata = r_wdata;
    assign bus_addr  = r_addr;
    assign rdata_out = r_rdata;
    assign stall     = rst_n & (w_start | (r_state == REQ));
    assign done      = rst_n & ((r_state == DONE) | w_illegal);
    assign err       = rst_n & (w_illegal | ((r_state == DONE) & r_tmo));
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table of single accesses plus hand-written multi-cycle sequences.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n, mem_read, mem_write, bus_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, bus_rdata;
    logic [31:0] rdata_out, bus_addr, bus_wdata;
    logic        stall, done, err, bus_req, bus_we;
    logic [3:0]  bus_be;

    int n_tests = 0;
    int n_fail  = 0;

    load_store_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata_out(rdata_out),
        .stall(stall), .done(done), .err(err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] bwd;
        logic [31:0] exp_rd;
        logic        is_err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat);
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        bus_rdata = rdat;
    endtask

    initial begin
        vec_t v;
        int   n_stall, n_reqc, n_done;

        //          rd    wr    f3      addr          wdata         bus_rdata     be       bus_wdata     rdata_out     err
        tbl[0]  = '{1'b1, 1'b0, 3'b100, 32'h00000011, 32'h0,        32'h0000AB00, 4'b0010, 32'h0,        32'h000000AB, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'b001, 32'h00000022, 32'h0,        32'h80010000, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'b010, 32'h00000040, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 3'b001, 32'h00002002, 32'h0000BEEF, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 3'b000, 32'h00000005, 32'h123456A5, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'b010, 32'h00000008, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'b000, 32'h00000000, 32'h0,        32'h0000007F, 4'b0001, 32'h0,        32'h0000007F, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'b101, 32'h00000002, 32'h0,        32'hFFEE0000, 4'b1100, 32'h0,        32'h0000FFEE, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'b010, 32'h00000001, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000FFEE, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 3'b001, 32'h00000003, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000FFEE, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 3'b011, 32'h00000000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000FFEE, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 3'b100, 32'h00000000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000FFEE, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 3'b010, 32'h00000000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000FFEE, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 3'b111, 32'h00000000, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000FFEE, 1'b1};

        rst_n   = 1'b0;
        bus_ack = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata_out, 0);
        chk("rst_stall", stall, 0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            v = tbl[i];
            drive(v.rd, v.wr, v.f3, v.addr, v.wdata, 32'h0);
            #1;
            if (v.is_err) begin
                chk($sformatf("v%0d_err", i), err, 1);
                chk($sformatf("v%0d_done", i), done, 1);
                chk($sformatf("v%0d_stall", i), stall, 0);
                chk($sformatf("v%0d_req", i), bus_req, 0);
                tick();
                chk($sformatf("v%0d_req_after", i), bus_req, 0);
                drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
                #1;
                chk($sformatf("v%0d_err_clear", i), err, 0);
                chk($sformatf("v%0d_rdata", i), rdata_out, v.exp_rd);
            end else begin
                chk($sformatf("v%0d_stall0", i), stall, 1);
                chk($sformatf("v%0d_done0", i), done, 0);
                tick();
                chk($sformatf("v%0d_req", i), bus_req, 1);
                chk($sformatf("v%0d_we", i), bus_we, v.wr);
                chk($sformatf("v%0d_addr", i), bus_addr, v.addr & 32'hFFFFFFFC);
                chk($sformatf("v%0d_be", i), bus_be, v.be);
                chk($sformatf("v%0d_wdata", i), bus_wdata, v.bwd);
                bus_ack   = 1'b1;
                bus_rdata = v.rdata;
                tick();
                bus_ack = 1'b0;
                chk($sformatf("v%0d_done", i), done, 1);
                chk($sformatf("v%0d_err", i), err, 0);
                chk($sformatf("v%0d_stall_done", i), stall, 0);
                chk($sformatf("v%0d_rdata", i), rdata_out, v.exp_rd);
                drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
                tick();
                chk($sformatf("v%0d_idle_done", i), done, 0);
                chk($sformatf("v%0d_idle_req", i), bus_req, 0);
            end
        end

        // LB with ack one cycle late: done must land at cycle 3.
        drive(1'b1, 1'b0, 3'b000, 32'h00001003, 32'h0, 32'h80000000);
        tick();
        chk("lb_c1_be", bus_be, 4'b1000);
        chk("lb_c1_done", done, 0);
        tick();
        chk("lb_c2_req", bus_req, 1);
        chk("lb_c2_done", done, 0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("lb_c3_done", done, 1);
        chk("lb_rdata", rdata_out, 32'hFFFFFF80);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();

        // LHU with immediate ack: stall visible for exactly two cycles.
        drive(1'b1, 1'b0, 3'b101, 32'h00000002, 32'h0, 32'hFFEE0000);
        n_stall = 0;
        #1;
        if (stall) n_stall++;
        tick();
        bus_ack = 1'b1;
        for (int c = 0; c < 10 && !done; c++) begin
            if (stall) n_stall++;
            tick();
            bus_ack = 1'b0;
        end
        bus_ack = 1'b0;
        chk("lhu_done", done, 1);
        chk("lhu_stall_cycles", n_stall, 2);
        chk("lhu_rdata", rdata_out, 32'h0000FFEE);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();

        // No ack at all: abort after 16 request cycles.
        drive(1'b1, 1'b0, 3'b010, 32'h00000100, 32'h0, 32'h55555555);
        tick();
        n_reqc = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus_req) n_reqc++;
            tick();
        end
        chk("tmo_done", done, 1);
        chk("tmo_err", err, 1);
        chk("tmo_req_cycles", n_reqc, 16);
        chk("tmo_rdata", rdata_out, 0);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        chk("tmo_idle_req", bus_req, 0);
        chk("tmo_idle_done", done, 0);
        chk("tmo_idle_err", err, 0);

        // Ack on the final request cycle beats the timeout.
        drive(1'b1, 1'b0, 3'b010, 32'h00000200, 32'h0, 32'h11223344);
        tick();
        for (int c = 0; c < 15; c++) tick();
        chk("race_req", bus_req, 1);
        chk("race_done_early", done, 0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        chk("race_done", done, 1);
        chk("race_err", err, 0);
        chk("race_rdata", rdata_out, 32'h11223344);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();

        // Reset during REQ, then a stray ack while idle.
        drive(1'b1, 1'b0, 3'b010, 32'h00000300, 32'h0, 32'hA5A5A5A5);
        tick();
        chk("rmid_req", bus_req, 1);
        rst_n = 1'b0;
        tick();
        chk("rmid_req_drop", bus_req, 0);
        chk("rmid_stall", stall, 0);
        chk("rmid_rdata", rdata_out, 0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hA5A5A5A5);
        bus_ack = 1'b1;
        n_done = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done || bus_req) n_done++;
        end
        bus_ack = 1'b0;
        chk("rmid_late_ack", n_done, 0);
        chk("rmid_rdata_hold", rdata_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the maximum number of cycles in REQ without bus_ack before abort.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have port mem_read, input, 1, load request from control.
REQ-005 The block SHALL have port mem_write, input, 1, store request from control.
REQ-006 The block SHALL have port funct3, input, 3, access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 The block SHALL have ports addr and wdata, inputs, 32 each, the effective address and the store data.
REQ-008 The block SHALL have port rdata_out, output, 32, the extended load result.
REQ-009 The block SHALL have ports stall, done and err, outputs, 1 each: pipeline hold, access complete, and access fault.
REQ-010 The block SHALL have ports bus_req, bus_we, bus_addr[31:0], bus_wdata[31:0] and bus_be[3:0], outputs, forming the memory-side request.
REQ-011 The block SHALL have ports bus_ack and bus_rdata[31:0], inputs, forming the memory-side response.

Function
REQ-012 The FSM SHALL have states IDLE, REQ and DONE.
REQ-013 Access start: in IDLE, with exactly one of mem_read/mem_write high, legal funct3, and aligned addr, the next state SHALL be REQ.
REQ-014 Alignment: H/HU SHALL require addr[0]=0; W SHALL require addr[1:0]=00; B/BU SHALL always be aligned.
REQ-015 Illegal access (misaligned, funct3 in {011,110,111}, funct3 in {100,101} on a store, or mem_read and mem_write both high) in IDLE SHALL pulse err=1 and done=1 for that cycle only, SHALL leave bus_req 0 and stall 0, and SHALL keep the state IDLE.
REQ-016 stall SHALL be combinationally 1 in IDLE when a legal access starts, and 1 throughout REQ; in DONE it SHALL be 0.
REQ-017 While stall=1, the inputs SHALL be held stable by the pipeline.
REQ-018 In REQ, bus_req SHALL be 1 and bus_addr SHALL be {addr[31:2],2'b00}.
REQ-019 bus_we SHALL equal the registered mem_write.
REQ-020 Stores: bus_be SHALL be 0001<<addr[1:0] for B, 0011<<{addr[1],1'b0} for H, and 1111 for W.
REQ-021 Stores: bus_wdata SHALL be the byte replicated x4 for B, the halfword replicated x2 for H, and wdata for W.
REQ-022 Loads: bus_be SHALL be driven as for stores and bus_wdata SHALL be 0.
REQ-023 Once bus_ack=1 in REQ, the next state SHALL be DONE; on a load, the selected lane SHALL be captured, sign-extended (B/H) or zero-extended (BU/HU), into rdata_out.
REQ-024 DONE SHALL last one cycle with done=1, and SHALL then go unconditionally to IDLE without restarting on the still-present request.
REQ-025 Latency: request seen at cycle 0 with bus_ack at cycle k≥1 SHALL give done=1 at cycle k+1.
REQ-026 Timeout counter: it SHALL reset to 0 on REQ entry, increment each REQ cycle without ack, and at TIMEOUT go to DONE with err=1 and rdata_out=0.
REQ-027 If bus_ack coincides with the timeout cycle, the ack SHALL win and err SHALL be 0.
REQ-028 bus_ack outside REQ SHALL be ignored.
REQ-029 rdata_out SHALL hold its value until the next load completes; a store SHALL NOT modify it.

Reset
REQ-030 rst_n=0 at a clock edge SHALL set state IDLE, counter 0, rdata_out 0, and bus_req, bus_we, bus_be, bus_wdata, done, err to 0; stall SHALL be 0 while rst_n=0.
REQ-031 Reset mid-REQ SHALL drop bus_req at that edge, and any later bus_ack SHALL be ignored.

Verification
REQ-032 Scenario LB: addr=0x1003, funct3=000, bus_rdata=0x80000000, ack at cycle 2 -> bus_be=1000, done at cycle 3, rdata_out=0xFFFFFF80.
REQ-033 Scenario SH: addr=0x2002, wdata=0x0000BEEF -> bus_we=1, bus_be=1100, bus_wdata=0xBEEFBEEF; rdata_out unchanged.
REQ-034 Scenario LW misaligned: addr=0x0001 -> err=1 and done=1 for one cycle, bus_req never 1, stall 0.
REQ-035 Scenario timeout: TIMEOUT=16, no ack -> done=1 with err=1 after 16 REQ cycles, rdata_out=0, then IDLE.
REQ-036 Scenario reset mid-access: rst_n=0 during REQ -> bus_req=0 next cycle, a late ack produces no done.
REQ-037 Scenario LHU: addr=0x0002, bus_rdata=0xFFEE0000, ack immediate -> rdata_out=0x0000FFEE, stall high exactly 2 cycles.
